register_file_onehot: RTL

- 32-entry x 32-bit register file for the processor datapath, one write port, two read ports.
- Sits directly downstream of the register-select decoder and consumes its 32-bit one-hot write-select word as the write-enable vector.
- Registered read outputs with same-cycle write-to-read bypass.
- Sticky error flag reports any write-select word that is not one-hot, and the illegal write is suppressed.

---
 rtl/register_file_onehot.sv | 52 +++++
 1 files changed

// File: rtl/register_file_onehot.sv
// register_file_onehot: 32 x WIDTH register file with a one-hot write port,
// two registered read ports, write-to-read bypass and a sticky illegal-select flag.
module register_file_onehot #(
    parameter int WIDTH    = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [31:0]      wr_sel,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [4:0]       rd_addr_a,
    input  logic [4:0]       rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             sel_err,
    output logic [7:0]       wr_count
);
    logic [WIDTH-1:0] r_regs [32];
    logic             w_onehot;
    logic             w_legal;
    logic             w_illegal;
    logic [WIDTH-1:0] w_next_a;
    logic [WIDTH-1:0] w_next_b;
    // wr_en gates everything so an X or multi-hot select is harmless while idle
    always_comb begin
        w_onehot  = (wr_sel != 32'd0) && ((wr_sel & (wr_sel - 32'd1)) == 32'd0);
        w_legal   = wr_en && w_onehot;
        w_illegal = wr_en && !w_onehot;
        w_next_a  = (ZERO_REG != 0 && rd_addr_a == 5'd0) ? '0 :
                    (BYPASS != 0 && w_legal && wr_sel[rd_addr_a]) ? wr_data : r_regs[rd_addr_a];
        w_next_b  = (ZERO_REG != 0 && rd_addr_b == 5'd0) ? '0 :
                    (BYPASS != 0 && w_legal && wr_sel[rd_addr_b]) ? wr_data : r_regs[rd_addr_b];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
            rd_data_a <= '0;
            rd_data_b <= '0;
            sel_err   <= 1'b0;
            wr_count  <= 8'd0;
        end else begin
            for (int i = 0; i < 32; i++)
                if (w_legal && wr_sel[i] && !(ZERO_REG != 0 && i == 0)) r_regs[i] <= wr_data;
            rd_data_a <= w_next_a;
            rd_data_b <= w_next_b;
            if (w_illegal) sel_err <= 1'b1;
            if (w_legal) wr_count <= wr_count + 8'd1;
        end
    end
endmodule
